forward_hazard_ctrl: RTL and testbench

FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

---
 rtl/forward_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_forward_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// forward_hazard_ctrl
//
// Forwarding and load-use hazard control for a classic 5-stage in-order
// pipeline. A two-entry scoreboard shadows the destination registers of the
// instructions now in EX and MEM. The block uses it to pick the EX-stage
// operand mux selects for the instruction leaving ID. It also detects the
// single load-use case that forwarding cannot cover and inserts one bubble for
// it.
//
// Ports
//   clk          pipeline clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   id_valid     ID stage holds a real instruction
//   id_rs1       first source register of the ID instruction
//   id_rs2       second source register of the ID instruction
//   id_rd        destination register of the ID instruction
//   id_regwrite  ID instruction writes id_rd
//   id_memread   ID instruction is a load
//   flush        squash the instruction leaving ID this cycle
//   stall        combinational; hold PC and IF/ID, bubble into EX
//   fwd_a        registered operand-A select: 00 ID/EX, 01 MEM/WB, 10 EX/MEM
//   fwd_b        registered operand-B select, same encoding as fwd_a
//   ex_valid     registered; EX holds a real, non-bubble instruction
//   stall_count  registered, saturating count of stall cycles
// -----------------------------------------------------------------------------
module forward_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        ex_valid,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    FWD_IDEX  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } ex_entry_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
  } mem_entry_t;

  ex_entry_t  ex_q;
  ex_entry_t  ex_d;
  mem_entry_t mem_q;
  fwd_sel_e   fwd_a_d;
  fwd_sel_e   fwd_b_d;

  logic ex_hit_rs1;
  logic ex_hit_rs2;
  logic mem_hit_rs1;
  logic mem_hit_rs2;
  logic advance;

  // x0 is hard-wired to zero, so it never counts as a produced value even if
  // an instruction claims to write it.
  function automatic logic produces(input logic       valid,
                                    input logic       regwrite,
                                    input logic [4:0] rd,
                                    input logic [4:0] src);
    return valid && regwrite && (rd != 5'd0) && (rd == src);
  endfunction

  // The younger producer (EX) shadows the older one (MEM).
  function automatic fwd_sel_e pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit)  return FWD_EXMEM;
    if (mem_hit) return FWD_MEMWB;
    return FWD_IDEX;
  endfunction

  assign ex_hit_rs1  = produces(ex_q.valid,  ex_q.regwrite,  ex_q.rd,  id_rs1);
  assign ex_hit_rs2  = produces(ex_q.valid,  ex_q.regwrite,  ex_q.rd,  id_rs2);
  assign mem_hit_rs1 = produces(mem_q.valid, mem_q.regwrite, mem_q.rd, id_rs1);
  assign mem_hit_rs2 = produces(mem_q.valid, mem_q.regwrite, mem_q.rd, id_rs2);

  // A load in EX has no data yet, so a consumer right behind it must wait one
  // cycle. Next cycle the load sits in MEM and is forwarded from MEM/WB. A
  // flushed instruction is discarded anyway, so flush masks the hazard.
  assign stall   = id_valid && !flush && ex_q.memread && (ex_hit_rs1 || ex_hit_rs2);
  assign advance = id_valid && !flush && !stall;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    ex_d    = '0;
    fwd_a_d = FWD_IDEX;
    fwd_b_d = FWD_IDEX;
    if (advance) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      fwd_a_d       = pick(ex_hit_rs1, mem_hit_rs1);
      fwd_b_d       = pick(ex_hit_rs2, mem_hit_rs2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      fwd_a       <= FWD_IDEX;
      fwd_b       <= FWD_IDEX;
      stall_count <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the pre-edge
      // value of the stage in front of it, so MEM gets the old EX entry.
      // MEM never stalls: it always takes whatever EX held, bubble or not.
      mem_q.valid    <= ex_q.valid;
      mem_q.rd       <= ex_q.rd;
      mem_q.regwrite <= ex_q.regwrite;
      ex_q           <= ex_d;
      fwd_a          <= fwd_a_d;
      fwd_b          <= fwd_b_d;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

  assign ex_valid = ex_q.valid;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_forward_hazard_ctrl
//
// Scoreboard bench for forward_hazard_ctrl. The stimulus process drives ID
// inputs on the falling edge and pushes the expected snapshot of all outputs
// for that cycle. The monitor process pops an entry and compares it 2 ns
// later. Directed vectors carry hand-computed values. A random stream takes
// its expectations from a small reference model. Asynchronous-reset and
// saturation cases are checked inline.
// -----------------------------------------------------------------------------
module tb_forward_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        ex_valid;
  logic [31:0] stall_count;

  forward_hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .stall       (stall),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .ex_valid    (ex_valid),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        ev;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_dir  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares one snapshot per cycle, well after the inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".stall"},       32'(stall),       32'(e.st));
        check({e.tag, ".fwd_a"},       32'(fwd_a),       32'(e.fa));
        check({e.tag, ".fwd_b"},       32'(fwd_b),       32'(e.fb));
        check({e.tag, ".ex_valid"},    32'(ex_valid),    32'(e.ev));
        check({e.tag, ".stall_count"}, stall_count,      e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic set_id(input int iv, input int rs1, input int rs2, input int rd,
                        input int rw, input int mr, input int fl);
    id_valid    = iv[0];
    id_rs1      = 5'(rs1);
    id_rs2      = 5'(rs2);
    id_rd       = 5'(rd);
    id_regwrite = rw[0];
    id_memread  = mr[0];
    flush       = fl[0];
  endtask

  // Directed vector: ID inputs for this cycle, then the outputs expected while
  // those inputs are applied.
  task automatic dvec(input int iv, input int rs1, input int rs2, input int rd,
                      input int rw, input int mr, input int fl,
                      input int st, input int fa, input int fb, input int ev, input int cnt);
    exp_t e;
    @(negedge clk);
    set_id(iv, rs1, rs2, rd, rw, mr, fl);
    e.st  = st[0];
    e.fa  = 2'(fa);
    e.fb  = 2'(fb);
    e.ev  = ev[0];
    e.cnt = 32'(cnt);
    e.tag = $sformatf("dir%0d", n_dir);
    n_dir++;
    q.push_back(e);
  endtask

  task automatic nop(input int fa, input int fb, input int ev, input int cnt);
    dvec(0, 0, 0, 0, 0, 0, 0, 0, fa, fb, ev, cnt);
  endtask

  // Reference model for the random stream.
  logic        m_ex_v, m_ex_rw, m_ex_mr, m_mem_v, m_mem_rw;
  logic [4:0]  m_ex_rd, m_mem_rd;
  logic [1:0]  m_fa, m_fb;
  logic [31:0] m_cnt;

  task automatic model_clear();
    m_ex_v = 0; m_ex_rw = 0; m_ex_mr = 0; m_ex_rd = 0;
    m_mem_v = 0; m_mem_rw = 0; m_mem_rd = 0;
    m_fa = 0; m_fb = 0; m_cnt = 0;
  endtask

  function automatic logic [1:0] sel(input logic e, input logic m);
    if (e) return 2'b10;
    if (m) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_cycle(input int k, output logic st);
    logic e1, e2, m1, m2, go;
    exp_t e;
    e1 = m_ex_v  && m_ex_rw  && (m_ex_rd  != 0) && (m_ex_rd  == id_rs1);
    e2 = m_ex_v  && m_ex_rw  && (m_ex_rd  != 0) && (m_ex_rd  == id_rs2);
    m1 = m_mem_v && m_mem_rw && (m_mem_rd != 0) && (m_mem_rd == id_rs1);
    m2 = m_mem_v && m_mem_rw && (m_mem_rd != 0) && (m_mem_rd == id_rs2);
    st = id_valid && !flush && m_ex_mr && (e1 || e2);
    e.st = st; e.fa = m_fa; e.fb = m_fb; e.ev = m_ex_v; e.cnt = m_cnt;
    e.tag = $sformatf("rnd%0d", k);
    q.push_back(e);
    go = id_valid && !flush && !st;
    if (st && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 1;
    m_mem_v = m_ex_v; m_mem_rd = m_ex_rd; m_mem_rw = m_ex_rw;
    m_fa = go ? sel(e1, m1) : 2'b00;
    m_fb = go ? sel(e2, m2) : 2'b00;
    m_ex_v  = go;
    m_ex_rd = go ? id_rd : 5'd0;
    m_ex_rw = go && id_regwrite;
    m_ex_mr = go && id_memread;
  endtask

  initial begin
    logic held;
    logic st;

    reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset.stall",       32'(stall),    32'd0);
    check("reset.fwd_a",       32'(fwd_a),    32'd0);
    check("reset.fwd_b",       32'(fwd_b),    32'd0);
    check("reset.ex_valid",    32'(ex_valid), 32'd0);
    check("reset.stall_count", stall_count,   32'd0);
    @(negedge clk);
    reset = 1'b0;

    //    iv rs1 rs2 rd rw mr fl | st fa fb ev cnt
    dvec(1,  1,  2,  5, 1, 0, 0,   0, 0, 0, 0, 0);  // add x5
    dvec(1,  5,  3,  6, 1, 0, 0,   0, 0, 0, 1, 0);  // sub rs1=x5
    nop(                           2, 0, 1, 0);     // sub in EX: fwd_a=10
    dvec(1,  1,  2,  5, 1, 0, 0,   0, 0, 0, 0, 0);  // add x5
    nop(                           0, 0, 1, 0);
    dvec(1,  9,  5,  8, 1, 0, 0,   0, 0, 0, 0, 0);  // sub rs2=x5
    dvec(1,  2,  0,  7, 1, 1, 0,   0, 0, 1, 1, 0);  // ld x7; sub in EX: fwd_b=01
    dvec(1,  7,  7, 10, 1, 0, 0,   1, 0, 0, 1, 0);  // add x7,x7: load-use stall
    dvec(1,  7,  7, 10, 1, 0, 0,   0, 0, 0, 0, 1);  // held; bubble in EX
    nop(                           1, 1, 1, 1);     // add in EX: both 01
    dvec(1,  1,  0,  0, 1, 0, 0,   0, 0, 0, 0, 1);  // addi x0
    dvec(1,  0,  0, 11, 1, 0, 0,   0, 0, 0, 1, 1);  // use x0
    dvec(1,  1,  0,  0, 1, 1, 0,   0, 0, 0, 1, 1);  // ld x0; use x0 in EX: 00
    dvec(1,  0,  0, 12, 1, 0, 0,   0, 0, 0, 1, 1);  // use x0 behind ld x0: no stall
    dvec(1,  1,  2,  3, 1, 0, 0,   0, 0, 0, 1, 1);  // add x3 (older)
    dvec(1,  4,  4,  3, 1, 0, 0,   0, 0, 0, 1, 1);  // add x3 (younger)
    dvec(1,  3,  3, 13, 1, 0, 0,   0, 0, 0, 1, 1);  // use x3
    nop(                           2, 2, 1, 1);     // youngest producer wins
    dvec(1,  1,  0, 14, 1, 1, 0,   0, 0, 0, 0, 1);  // ld x14
    dvec(1, 14,  2, 15, 1, 0, 1,   0, 0, 0, 1, 1);  // load-use but flushed
    nop(                           0, 0, 0, 1);     // bubble, count unchanged
    dvec(1,  1,  2, 16, 1, 0, 0,   0, 0, 0, 0, 1);  // add x16
    dvec(1,  1,  2, 17, 1, 0, 0,   0, 0, 0, 1, 1);  // add x17
    dvec(1, 17, 16, 18, 1, 0, 0,   0, 0, 0, 1, 1);  // rs1 from EX, rs2 from MEM
    nop(                           2, 1, 1, 1);
    @(negedge clk);
    #3;

    // Reset asserted in the middle of a stall cycle.
    set_id(1, 1, 0, 20, 1, 1, 0);                   // ld x20
    @(negedge clk);
    set_id(1, 1, 20, 21, 1, 0, 0);                  // add rs2=x20
    #2;
    check("rststall.stall_before", 32'(stall), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rststall.stall",       32'(stall),    32'd0);
    check("rststall.fwd_a",       32'(fwd_a),    32'd0);
    check("rststall.fwd_b",       32'(fwd_b),    32'd0);
    check("rststall.ex_valid",    32'(ex_valid), 32'd0);
    check("rststall.stall_count", stall_count,   32'd0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("rststall.no_residual", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    check("rststall.first_adv_ex_valid", 32'(ex_valid), 32'd1);
    check("rststall.first_adv_fwd_b",    32'(fwd_b),     32'd0);
    check("rststall.first_adv_count",    stall_count,    32'd0);

    // Saturation: preload the counter just below the top, then stall twice.
    @(negedge clk);
    set_id(1, 1, 0, 22, 1, 1, 0);                   // ld x22
    force dut.stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count;
    @(negedge clk);
    set_id(1, 22, 0, 23, 1, 1, 0);                  // ld x23 uses x22
    #2;
    check("sat.stall1", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    check("sat.reach_max", stall_count, 32'hFFFF_FFFF);
    @(negedge clk);
    #2;
    check("sat.bubble_no_stall", 32'(stall), 32'd0);
    @(negedge clk);
    set_id(1, 23, 0, 24, 1, 0, 0);                  // add uses x23
    #2;
    check("sat.stall2", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    check("sat.hold_max", stall_count, 32'hFFFF_FFFF);

    // Random stream against the reference model.
    @(negedge clk);
    reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    held = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!held) begin
        set_id(($urandom_range(99) < 85) ? 1 : 0,
               int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
               ($urandom_range(99) < 80) ? 1 : 0,
               ($urandom_range(99) < 35) ? 1 : 0, 0);
      end
      flush = ($urandom_range(99) < 10);
      model_cycle(k, st);
      held = st;
    end
    @(negedge clk);
    #3;
    check("scoreboard.drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
